// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared types and constants for the seven-segment scan controller.
//   - state_t   : scan FSM states (blanking gap / digit lit)
//   - SEG_HEX   : hex digit to segment pattern table, bit7 = dp (always 0),
//                 bits6..0 = g..a, active-high
//   - SEG_BLANK : all segments off
package seg_scan_pkg;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // Entry k holds the pattern for hex digit k (entry 15 is the leftmost literal).
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h27, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
//   Combinational 4-bit hex to seven-segment decoder.
// Ports
//   i_nibble  in   4  hex value 0..F
//   o_seg     out  8  {dp, g..a}, active-high, dp always 0
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   One digit is lit at a time, each slot preceded by an all-off gap to avoid
//   ghosting. New nibbles/enables are staged by load and only take effect at a
//   frame boundary, so a frame never mixes old and new data.
// Parameters
//   NUM_DIGITS    digits scanned (2..8)
//   DWELL_CYCLES  cycles each digit slot is lit (>=1)
//   GAP_CYCLES    all-off cycles before each slot (0 = no gap)
// Ports
//   clk_input   in   1             clock
//   rst         in   1             asynchronous active-high reset
//   digit_data  in   4*NUM_DIGITS  nibble k = digit_data[4k+3:4k], digit 0 rightmost
//   digit_en    in   NUM_DIGITS    per-digit enable
//   load        in   1             strobe staging digit_data/digit_en
//   Enable      out  NUM_DIGITS    one-hot active-high digit select
//   SevenSeg    out  8             {dp, g..a}, active-high
//   frame_done  out  1             one-cycle pulse after the last slot ends
// Configuration
//   SEG_LEADING_BLANK_EN : when defined, leading zero digits (from the top
//   digit downward, never digit 0) are blanked.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 524288,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                    clk_input,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   Enable,
  output logic [7:0]              SevenSeg,
  output logic                    frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_stage_data;
  logic [NUM_DIGITS-1:0]   r_stage_en;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_en;
  logic [NUM_DIGITS-1:0]   r_enable;
  logic [7:0]              r_seg;
  logic                    r_frame_done;

  state_t                  w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic                    w_slot_end;
  logic                    w_boundary;
  logic [4*NUM_DIGITS-1:0] w_shadow_data_next;
  logic [NUM_DIGITS-1:0]   w_shadow_en_next;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lead_blank;
  logic [NUM_DIGITS-1:0]   w_en_eff;
  logic                    w_digit_lit;
  logic [7:0]              w_seg;

  // Slot sequencing. The counter counts down to 0 and reloads on every state change.
  always_comb begin
    w_slot_end   = (r_cnt == '0);
    w_boundary   = (r_state == ST_ON) && w_slot_end && (r_idx == LAST_IDX);
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt - CNT_W'(1);
    if (w_slot_end) begin
      if (r_state == ST_GAP) begin
        w_state_next = ST_ON;
        w_cnt_next   = DWELL_LOAD;
      end else begin
        w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        if (GAP_CYCLES == 0) begin
          w_state_next = ST_ON;
          w_cnt_next   = DWELL_LOAD;
        end else begin
          w_state_next = ST_GAP;
          w_cnt_next   = GAP_LOAD;
        end
      end
    end
  end

  // Shadow update at the frame boundary; a load on that very cycle bypasses staging.
  always_comb begin
    w_shadow_data_next = r_shadow_data;
    w_shadow_en_next   = r_shadow_en;
    if (w_boundary) begin
      if (load) begin
        w_shadow_data_next = digit_data;
        w_shadow_en_next   = digit_en;
      end else if (r_pending) begin
        w_shadow_data_next = r_stage_data;
        w_shadow_en_next   = r_stage_en;
      end
    end
  end

  // Outputs are registered for the upcoming state, so they are decoded from
  // the next-cycle shadow and index.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = w_shadow_data_next[4*gi +: 4];
    end
  endgenerate

`ifdef SEG_LEADING_BLANK_EN
  // Run of zero nibbles from the top digit down; digit 0 is never blanked.
  always_comb begin : lead_blank
    logic v_zero_run;
    w_lead_blank = '0;
    v_zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_run      = v_zero_run & (w_nib[k] == 4'h0);
      w_lead_blank[k] = v_zero_run;
    end
  end
`else
  assign w_lead_blank = '0;
`endif

  assign w_en_eff    = w_shadow_en_next & ~w_lead_blank;
  assign w_digit_lit = (w_state_next == ST_ON) && w_en_eff[w_idx_next];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nib[w_idx_next]),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      r_state       <= ST_GAP;
      r_cnt         <= GAP_LOAD;
      r_idx         <= '0;
      r_stage_data  <= '0;
      r_stage_en    <= '0;
      r_pending     <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_en   <= '0;
      r_enable      <= '0;
      r_seg         <= SEG_BLANK;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_shadow_data <= w_shadow_data_next;
      r_shadow_en   <= w_shadow_en_next;
      if (load) begin
        r_stage_data <= digit_data;
        r_stage_en   <= digit_en;
      end
      // The boundary consumes any pending update (or a same-cycle load).
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
      r_frame_done <= w_boundary;
      if (w_digit_lit) begin
        r_enable <= NUM_DIGITS'(1) << w_idx_next;
        r_seg    <= w_seg;
      end else begin
        r_enable <= '0;
        r_seg    <= SEG_BLANK;
      end
    end
  end

  assign Enable     = r_enable;
  assign SevenSeg   = r_seg;
  assign frame_done = r_frame_done;

endmodule
